// File: rtl/maze_pkg.sv
// Shared types and constants for the maze game blocks: direction and
// movement-FSM encodings, start cell and default coordinate width.
package maze_pkg;

    localparam int COORD_W_DEFAULT = 9;
    localparam int CNT_W_DEFAULT   = 16;
    localparam int START_X         = 1;
    localparam int START_Y         = 1;

    typedef enum logic [2:0] {
        NONE,
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        UPD,
        WIN
    } state_t;

endpackage

// File: rtl/maze_dir_arbiter.sv
// Fixed-priority encoder from the four button pulses to one direction:
// up > down > left > right, all other pulses in the cycle are ignored.
module maze_dir_arbiter
    import maze_pkg::*;
(
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    output dir_t dir
);

    always_comb begin
        // NOTE: assign a default before the priority chain so no path leaves
        // dir unassigned; a missing else would otherwise infer a latch.
        dir = NONE;
        if (btn_up)
            dir = UP;
        else if (btn_down)
            dir = DOWN;
        else if (btn_left)
            dir = LEFT;
        else if (btn_right)
            dir = RIGHT;
    end

endmodule

// File: rtl/maze_move_ctrl.sv
// Player-movement controller: arbitrates button presses, range-checks the target,
// reads the wall memory and commits legal moves. MAZE_MOVE_CNT_EN enables move_cnt.
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_sys,
    input  logic               enable,
    input  logic               restart,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic [COORD_W-1:0] size_x,
    input  logic [COORD_W-1:0] size_y,
    input  logic [COORD_W-1:0] exit_x,
    input  logic [COORD_W-1:0] exit_y,
    output logic               wall_rd_req,
    output logic [COORD_W-1:0] wall_rd_x,
    output logic [COORD_W-1:0] wall_rd_y,
    input  logic               wall_rd_ack,
    input  logic               wall_rd_data,
    output logic [COORD_W-1:0] my_x,
    output logic [COORD_W-1:0] my_y,
    output logic               arrived,
    output logic               busy,
    output logic [CNT_W-1:0]   move_cnt
);

    localparam logic [COORD_W-1:0] X0  = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y0  = COORD_W'(START_Y);
    localparam logic [COORD_W:0]   ONE = (COORD_W+1)'(1);

    state_t           state;
    dir_t             dir;
    logic             restart_pend;
    logic [COORD_W:0] tgt_x;
    logic [COORD_W:0] tgt_y;
    logic             in_range;
    logic             press_ok;
    logic             commit;
    logic             at_exit;

    maze_dir_arbiter u_arb (
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .dir       (dir)
    );

    // One guard bit: stepping left/up from 0 wraps to all-ones and fails the range check.
    always_comb begin
        tgt_x = {1'b0, my_x};
        tgt_y = {1'b0, my_y};
        case (dir)
            UP:      tgt_y = {1'b0, my_y} - ONE;
            DOWN:    tgt_y = {1'b0, my_y} + ONE;
            LEFT:    tgt_x = {1'b0, my_x} - ONE;
            RIGHT:   tgt_x = {1'b0, my_x} + ONE;
            default: ;
        endcase
    end

    assign in_range = (tgt_x < {1'b0, size_x}) && (tgt_y < {1'b0, size_y});
    assign press_ok = enable && !arrived && (dir != NONE) && in_range;
    assign at_exit  = (wall_rd_x == exit_x) && (wall_rd_y == exit_y);
    assign commit   = (state == REQ) && wall_rd_ack && !wall_rd_data && enable
                      && !restart && !restart_pend;

    // The update decision is taken on the ack edge so the new position shows in
    // N+2+L and IDLE can take the next press in that same cycle.
    always_ff @(posedge clk or posedge rst_sys) begin
        // NOTE: state registers use non-blocking assignments so every branch
        // sees pre-edge values regardless of statement order.
        if (rst_sys) begin
            state        <= IDLE;
            restart_pend <= 1'b0;
            wall_rd_req  <= 1'b0;
            wall_rd_x    <= '0;
            wall_rd_y    <= '0;
            my_x         <= X0;
            my_y         <= Y0;
            arrived      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (restart) begin
                        my_x    <= X0;
                        my_y    <= Y0;
                        arrived <= 1'b0;
                    end else if (press_ok) begin
                        state       <= REQ;
                        wall_rd_req <= 1'b1;
                        wall_rd_x   <= tgt_x[COORD_W-1:0];
                        wall_rd_y   <= tgt_y[COORD_W-1:0];
                        busy        <= 1'b1;
                    end
                end
                REQ: begin
                    if (restart) begin
                        my_x         <= X0;
                        my_y         <= Y0;
                        arrived      <= 1'b0;
                        restart_pend <= 1'b1;
                    end
                    if (wall_rd_ack) begin
                        wall_rd_req  <= 1'b0;
                        restart_pend <= 1'b0;
                        if (commit && at_exit) begin
                            my_x    <= wall_rd_x;
                            my_y    <= wall_rd_y;
                            arrived <= 1'b1;
                            state   <= WIN;
                        end else begin
                            if (commit) begin
                                my_x <= wall_rd_x;
                                my_y <= wall_rd_y;
                            end
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                UPD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                WIN: begin
                    if (restart) begin
                        my_x    <= X0;
                        my_y    <= Y0;
                        arrived <= 1'b0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAZE_MOVE_CNT_EN
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys)
            move_cnt <= '0;
        else if (restart)
            move_cnt <= '0;
        else if (commit && (move_cnt != {CNT_W{1'b1}}))
            move_cnt <= move_cnt + CNT_W'(1);
    end
`else
    assign move_cnt = '0;
`endif

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Self-checking bench for maze_move_ctrl: directed scenarios then random presses
// against a cell-level model of the player, the maze and the wall memory.
module tb_maze_move_ctrl;

    localparam int CW = 9;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_sys;
    logic          enable;
    logic          restart;
    logic          btn_up, btn_down, btn_left, btn_right;
    logic [CW-1:0] size_x, size_y, exit_x, exit_y;
    logic          wall_rd_req;
    logic [CW-1:0] wall_rd_x, wall_rd_y;
    logic          wall_rd_ack;
    logic          wall_rd_data;
    logic [CW-1:0] my_x, my_y;
    logic          arrived;
    logic          busy;
    logic [NW-1:0] move_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: player cell, arrival flag, move count, maze geometry and walls.
    int px, py, cnt_m, sx, sy, ex, ey;
    bit arr_m;
    bit wall [16][16];

    maze_move_ctrl dut (
        .clk          (clk),
        .rst_sys      (rst_sys),
        .enable       (enable),
        .restart      (restart),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .size_x       (size_x),
        .size_y       (size_y),
        .exit_x       (exit_x),
        .exit_y       (exit_y),
        .wall_rd_req  (wall_rd_req),
        .wall_rd_x    (wall_rd_x),
        .wall_rd_y    (wall_rd_y),
        .wall_rd_ack  (wall_rd_ack),
        .wall_rd_data (wall_rd_data),
        .my_x         (my_x),
        .my_y         (my_y),
        .arrived      (arrived),
        .busy         (busy),
        .move_cnt     (move_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef MAZE_MOVE_CNT_EN
        return cnt_m;
`else
        return 0;
`endif
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_x"}, 32'(my_x), px);
        check({tag, "_y"}, 32'(my_y), py);
        check({tag, "_arrived"}, 32'(arrived), 32'(arr_m));
        check({tag, "_busy"}, 32'(busy), 32'(arr_m));
        check({tag, "_cnt"}, 32'(move_cnt), exp_cnt());
    endtask

    task automatic set_dims(input int x, input int y, input int e_x, input int e_y);
        sx = x; sy = y; ex = e_x; ey = e_y;
        size_x = CW'(x); size_y = CW'(y);
        exit_x = CW'(e_x); exit_y = CW'(e_y);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        px = 1; py = 1; arr_m = 1'b0; cnt_m = 0;
        check_state("restart");
    endtask

    // mask = {up, down, left, right}; lat = ack latency in cycles after req rises.
    task automatic do_press(input logic [3:0] mask, input int lat);
        int  dx, dy, tx, ty;
        bit  exp_req;
        dx = 0; dy = 0;
        if (mask[3])      dy = -1;
        else if (mask[2]) dy = 1;
        else if (mask[1]) dx = -1;
        else if (mask[0]) dx = 1;
        tx = px + dx;
        ty = py + dy;
        exp_req = enable && !arr_m && (mask != 4'b0) &&
                  (tx >= 0) && (tx < sx) && (ty >= 0) && (ty < sy);
        {btn_up, btn_down, btn_left, btn_right} = mask;
        tick();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        check("req_rise", 32'(wall_rd_req), 32'(exp_req));
        if (exp_req) begin
            check("rd_x", 32'(wall_rd_x), tx);
            check("rd_y", 32'(wall_rd_y), ty);
            for (int i = 0; i < lat; i++) begin
                if (i == 0) btn_up = 1'b1;
                tick();
                btn_up = 1'b0;
                check("req_hold", 32'(wall_rd_req), 1);
                check("hold_x", 32'(my_x), px);
            end
            wall_rd_ack  = 1'b1;
            wall_rd_data = wall[tx][ty];
            tick();
            wall_rd_ack  = 1'b0;
            wall_rd_data = 1'b0;
            check("req_fall", 32'(wall_rd_req), 0);
            if (!wall[tx][ty]) begin
                px = tx; py = ty; cnt_m++;
                if (px == ex && py == ey) arr_m = 1'b1;
            end
        end else begin
            tick();
            check("req_idle", 32'(wall_rd_req), 0);
        end
        check_state("move");
    endtask

    initial begin
        rst_sys = 1'b1; enable = 1'b0; restart = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        wall_rd_ack = 1'b0; wall_rd_data = 1'b0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                wall[x][y] = 1'b0;
        set_dims(8, 8, 6, 6);
        px = 1; py = 1; arr_m = 1'b0; cnt_m = 0;

        repeat (2) tick();
        check_state("reset");
        check("reset_req", 32'(wall_rd_req), 0);
        check("reset_rdx", 32'(wall_rd_x), 0);
        check("reset_rdy", 32'(wall_rd_y), 0);
        rst_sys = 1'b0;
        enable  = 1'b1;
        tick();

        // Right press with L=2 and a drop-while-busy press; nothing may queue.
        do_press(4'b0001, 2);
        tick();
        check("no_queue", 32'(wall_rd_req), 0);

        // Up and left together from (1,1): up wins, read at (1,0).
        do_restart();
        do_press(4'b1010, 0);

        // Walk to (0,3), then left off the edge and down into a wall.
        wall[0][4] = 1'b1;
        do_press(4'b0100, 1);
        do_press(4'b0100, 0);
        do_press(4'b0100, 3);
        do_press(4'b0010, 0);
        do_press(4'b0010, 0);
        do_press(4'b0100, 1);

        // Reach the exit at (6,6), then presses are ignored until restart.
        for (int i = 0; i < 5; i++) do_press(4'b0001, i % 2);
        for (int i = 0; i < 3; i++) do_press(4'b0100, 0);
        do_press(4'b0001, 1);
        check("won", 32'(arrived), 1);
        do_press(4'b0010, 0);
        do_press(4'b1000, 0);
        do_restart();

        // Down press from (2,1) with enable dropping mid-request: result discarded.
        do_press(4'b0001, 0);
        btn_down = 1'b1;
        tick();
        btn_down = 1'b0;
        check("en_req", 32'(wall_rd_req), 1);
        enable = 1'b0;
        tick();
        check("en_hold", 32'(wall_rd_req), 1);
        wall_rd_ack = 1'b1;
        tick();
        wall_rd_ack = 1'b0;
        enable = 1'b1;
        check("en_fall", 32'(wall_rd_req), 0);
        check_state("en_drop");

        // Restart during a request whose ack is delayed: req held, ends at (1,1).
        btn_down = 1'b1;
        tick();
        btn_down = 1'b0;
        check("rs_req", 32'(wall_rd_req), 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        px = 1; py = 1; arr_m = 1'b0; cnt_m = 0;
        for (int i = 0; i < 3; i++) begin
            check("rs_hold", 32'(wall_rd_req), 1);
            tick();
        end
        wall_rd_ack = 1'b1;
        tick();
        wall_rd_ack = 1'b0;
        check("rs_fall", 32'(wall_rd_req), 0);
        check_state("rs_done");

        // Random presses over a random small maze.
        enable = 1'b0;
        tick();
        set_dims($urandom_range(4, 8), $urandom_range(4, 8), 0, 0);
        ex = $urandom_range(2, sx - 1);
        ey = $urandom_range(0, sy - 1);
        exit_x = CW'(ex); exit_y = CW'(ey);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                wall[x][y] = ($urandom_range(0, 3) == 0);
        wall[ex][ey] = 1'b0;
        do_restart();
        for (int n = 0; n < 120; n++) begin
            if (arr_m || $urandom_range(0, 24) == 0) do_restart();
            enable = ($urandom_range(0, 7) != 0);
            do_press(4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end
        enable = 1'b1;

        // Reset pulse in the middle of a request drops req at once.
        do_restart();
        wall[2][1] = 1'b0;
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        check("rst_req", 32'(wall_rd_req), 1);
        #2 rst_sys = 1'b1;
        #1;
        check("rst_drop", 32'(wall_rd_req), 0);
        px = 1; py = 1; arr_m = 1'b0; cnt_m = 0;
        check_state("rst_mid");
        check("rst_rdx", 32'(wall_rd_x), 0);
        tick();
        rst_sys = 1'b0;
        tick();
        check_state("rst_after");
        check("rst_idle", 32'(wall_rd_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
